pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central pipeline controller for the 5-stage core. Merges stall requests from the IF/ID/EX/MEM
//  stages into the 6-bit stall vector that drives pc_reg, if_id, id_ex, ex_mem and mem_wb.
//  Sequences multi-cycle divide operations and exception/redirect flushes. Keeps a stall-cycle
//  performance counter.
// PARAMETERS
//  DIV_TIMEOUT   64   max DIV_WAIT cycles before abort (>=2)
//  FLUSH_CYCLES  1    cycles flush_o stays high per flush (1..15)
//  CNT_W         32   width of stall_cnt_o
// PORTS
//  clk               in   1      clock, rising edge
//  rst               in   1      reset, asynchronous, active-high (`RstEnable = 1)
//  stallreq_from_if  in   1      fetch wait (instruction bus not ready)
//  stallreq_from_id  in   1      load-use hazard in decode
//  stallreq_from_ex  in   1      multi-cycle ALU op (madd/msub) in execute
//  stallreq_from_mem in   1      data bus wait
//  div_start_i       in   1      EX issues a divide this cycle
//  div_ready_i       in   1      divider result valid (1-cycle pulse)
//  flush_req_i       in   1      redirect/exception request from MEM
//  new_pc_i          in   32     redirect target, sampled with flush_req_i
//  stall             out  6      {wb,mem,ex,id,if,pc} stall bits, `Stop = 1
//  flush_o           out  1      clear all pipeline registers
//  new_pc_o          out  32     latched redirect target, valid while flush_o
//  div_cancel_o      out  1      1-cycle pulse: abort divider (flush or timeout)
//  div_busy_o        out  1      FSM in DIV_WAIT
//  stall_cnt_o       out  CNT_W  cycles with stall[0]=1, saturating
// BEHAVIOUR
//  Reset (async): state=IDLE, stall=6'b000000, flush_o=0, new_pc_o=0, div_cancel_o=0,
//   div_busy_o=0, stall_cnt_o=0, internal counters=0.
//  Stall encoding: combinational from the requests and the FSM state, same cycle.
//   Highest stage wins:
//   mem=6'b011111 > ex or DIV_WAIT=6'b001111 > id=6'b000111 > if=6'b000011 > none=6'b000000.
//   This lets id_ex insert a bubble when stall[2]=1 and stall[3]=0.
//  FSM states: IDLE, DIV_WAIT, FLUSH.
//   IDLE -> DIV_WAIT: div_start_i=1 and flush_req_i=0. Div counter cleared to 0.
//   DIV_WAIT: EX stall asserted while div_ready_i=0. Div counter increments each cycle.
//   DIV_WAIT -> IDLE on div_ready_i=1. In that cycle the EX stall from DIV_WAIT is dropped,
//    so the result advances on that edge.
//   DIV_WAIT -> IDLE on timeout: div counter reaches DIV_TIMEOUT-1 with no div_ready_i.
//    div_cancel_o pulses 1 cycle (registered). Stall released.
//   Any state -> FLUSH on flush_req_i=1. Flush has priority over div_start_i, div_ready_i and
//    all stall requests. new_pc_o <= new_pc_i.
//    If leaving DIV_WAIT this way, div_cancel_o pulses 1 cycle.
//   FLUSH: flush_o=1 (registered), stall=0 regardless of requests, for FLUSH_CYCLES cycles.
//    Then -> IDLE.
//    flush_req_i during FLUSH restarts the FLUSH count and relatches new_pc_o.
//    div_start_i during FLUSH is ignored.
//  Flush latency: flush_req_i at edge N -> flush_o=1 from N+1 through N+FLUSH_CYCLES.
//  new_pc_o holds its value after FLUSH until the next flush.
//  div_ready_i in IDLE or FLUSH is ignored.
//  div_start_i and div_ready_i together in IDLE: enter DIV_WAIT; ready is not consumed.
//  stall_cnt_o: +1 on each edge where stall[0]=1. Saturates at all-ones, no wrap.
//  Async reset mid-DIV_WAIT or mid-FLUSH: immediate return to reset values. No cancel pulse.
// TESTING
//  1 Priority: if=1,id=1 -> stall=000111; add mem=1 -> 011111; all requests low -> 000000
//    in the same cycle.
//  2 Divide: div_start_i at cycle 0, div_ready_i at cycle 5 -> div_busy_o=1 and
//    stall=001111 for cycles 1-4. Cycle 5: stall=000000. Cycle 6: div_busy_o=0.
//  3 Timeout: DIV_TIMEOUT=8, div_start_i with no ready -> stall held 8 cycles.
//    Then div_cancel_o=1 for 1 cycle, stall=0, state IDLE.
//  4 Flush during divide: flush_req_i in DIV_WAIT, new_pc_i=32'h0000_0040 -> next cycle
//    flush_o=1, new_pc_o=32'h40, div_cancel_o=1, stall=0 despite stallreq_from_mem=1.
//  5 Back-to-back flush: FLUSH_CYCLES=3, second flush_req_i (new_pc_i=32'h80) in 2nd flush cycle
//    -> flush_o stays high 3 more cycles, new_pc_o=32'h80.
//  6 Counter and reset: CNT_W=4, hold if stall 20 cycles -> stall_cnt_o=4'hF.
//    Assert rst mid-DIV_WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Signal bundle between the pipeline stages and the central stall/flush controller.
// The controller is the slave; the datapath stages that raise requests are the master.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stallreq_from_if;
    logic             stallreq_from_id;
    logic             stallreq_from_ex;
    logic             stallreq_from_mem;
    logic             div_start_i;
    logic             div_ready_i;
    logic             flush_req_i;
    logic [31:0]      new_pc_i;
    logic [5:0]       stall;
    logic             flush_o;
    logic [31:0]      new_pc_o;
    logic             div_cancel_o;
    logic             div_busy_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        output div_start_i, div_ready_i, flush_req_i, new_pc_i,
        input  stall, flush_o, new_pc_o, div_cancel_o, div_busy_o, stall_cnt_o
    );

    modport slave (
        input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
        input  div_start_i, div_ready_i, flush_req_i, new_pc_i,
        output stall, flush_o, new_pc_o, div_cancel_o, div_busy_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline controller: merges per-stage stall requests into the stall vector,
// sequences multi-cycle divides and redirect flushes, and counts stalled cycles.
module pipe_stall_ctrl #(
    parameter int DIV_TIMEOUT  = 64,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input logic              clk,
    input logic              rst,
    pipe_stall_ctrl_if.slave bus
);
    localparam int DIV_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        IDLE,
        DIV_WAIT,
        FLUSH
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic [3:0]       flush_cnt, flush_cnt_nxt;
    logic             cancel_nxt;
    logic             div_timeout;
    logic [5:0]       stall_vec;

    assign div_timeout = (state == DIV_WAIT) && !bus.div_ready_i &&
                         (div_cnt == DIV_W'(DIV_TIMEOUT - 1));

    // A pending or active flush discards everything in flight, so stalling it is pointless.
    always_comb begin
        stall_vec = STALL_NONE;
        if (state == FLUSH || bus.flush_req_i)
            stall_vec = STALL_NONE;
        else if (bus.stallreq_from_mem)
            stall_vec = STALL_MEM;
        else if (bus.stallreq_from_ex || (state == DIV_WAIT && !bus.div_ready_i))
            stall_vec = STALL_EX;
        else if (bus.stallreq_from_id)
            stall_vec = STALL_ID;
        else if (bus.stallreq_from_if)
            stall_vec = STALL_IF;
    end

    always_comb begin
        state_nxt     = state;
        div_cnt_nxt   = div_cnt;
        flush_cnt_nxt = flush_cnt;
        cancel_nxt    = 1'b0;
        if (bus.flush_req_i) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = '0;
            cancel_nxt    = (state == DIV_WAIT);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.div_start_i) begin
                        state_nxt   = DIV_WAIT;
                        div_cnt_nxt = '0;
                    end
                end
                DIV_WAIT: begin
                    if (bus.div_ready_i) begin
                        state_nxt = IDLE;
                    end else if (div_timeout) begin
                        state_nxt  = IDLE;
                        cancel_nxt = 1'b1;
                    end else begin
                        div_cnt_nxt = div_cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'(FLUSH_CYCLES - 1))
                        state_nxt = IDLE;
                    else
                        flush_cnt_nxt = flush_cnt + 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            div_cnt      <= '0;
            flush_cnt    <= '0;
            bus.new_pc_o     <= '0;
            bus.div_cancel_o <= 1'b0;
        end else begin
            state            <= state_nxt;
            div_cnt          <= div_cnt_nxt;
            flush_cnt        <= flush_cnt_nxt;
            bus.div_cancel_o <= cancel_nxt;
            if (bus.flush_req_i)
                bus.new_pc_o <= bus.new_pc_i;
        end
    end

    // Saturating performance counter of cycles in which the PC was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.stall_cnt_o <= '0;
        else if (stall_vec[0] && (bus.stall_cnt_o != {CNT_W{1'b1}}))
            bus.stall_cnt_o <= bus.stall_cnt_o + 1'b1;
    end

    assign bus.stall      = stall_vec;
    assign bus.flush_o    = (state == FLUSH);
    assign bus.div_busy_o = (state == DIV_WAIT);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed vectors push expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_stall_ctrl;
    localparam int CNT_W = 4;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_IF   = 6'b000011;
    localparam logic [5:0] S_ID   = 6'b000111;
    localparam logic [5:0] S_EX   = 6'b001111;
    localparam logic [5:0] S_MEM  = 6'b011111;

    localparam logic [5:0] M_STALL  = 6'b000001;
    localparam logic [5:0] M_FLUSH  = 6'b000010;
    localparam logic [5:0] M_PC     = 6'b000100;
    localparam logic [5:0] M_CANCEL = 6'b001000;
    localparam logic [5:0] M_BUSY   = 6'b010000;
    localparam logic [5:0] M_CNT    = 6'b100000;
    localparam logic [5:0] M_ALL    = 6'b111111;

    // Request vector order: {if, id, ex, mem, div_start, div_ready, flush}
    localparam logic [6:0] R_NONE = 7'b0000000;
    localparam logic [6:0] R_IF   = 7'b1000000;
    localparam logic [6:0] R_ID   = 7'b0100000;
    localparam logic [6:0] R_EX   = 7'b0010000;
    localparam logic [6:0] R_MEM  = 7'b0001000;
    localparam logic [6:0] R_DS   = 7'b0000100;
    localparam logic [6:0] R_DR   = 7'b0000010;
    localparam logic [6:0] R_FL   = 7'b0000001;

    typedef struct {
        int               cyc;
        string            name;
        logic [5:0]       mask;
        logic [5:0]       stall;
        logic             flush;
        logic [31:0]      pc;
        logic             cancel;
        logic             busy;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_stall_ctrl #(
        .DIV_TIMEOUT (8),
        .FLUSH_CYCLES(3),
        .CNT_W       (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic applyStimulus(input logic [6:0] req, input logic [31:0] pc);
        @(posedge clk);
        #1;
        {bus.stallreq_from_if, bus.stallreq_from_id, bus.stallreq_from_ex, bus.stallreq_from_mem,
         bus.div_start_i, bus.div_ready_i, bus.flush_req_i} = req;
        bus.new_pc_i = pc;
    endtask

    task automatic expectNow(input string name, input logic [5:0] mask, input logic [5:0] st,
                             input logic fl, input logic [31:0] pc, input logic cn,
                             input logic bz, input logic [CNT_W-1:0] ct);
        exp_t e;
        e.cyc    = cyc;
        e.name   = name;
        e.mask   = mask;
        e.stall  = st;
        e.flush  = fl;
        e.pc     = pc;
        e.cancel = cn;
        e.busy   = bz;
        e.cnt    = ct;
        exp_q.push_back(e);
    endtask

    task automatic cmpField(input string name, input string field,
                            input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s.%s @cycle %0d: got %h, expected %h", name, field, cyc, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.mask[0]) cmpField(e.name, "stall",     32'(bus.stall),        32'(e.stall));
        if (e.mask[1]) cmpField(e.name, "flush_o",   32'(bus.flush_o),      32'(e.flush));
        if (e.mask[2]) cmpField(e.name, "new_pc_o",  bus.new_pc_o,          e.pc);
        if (e.mask[3]) cmpField(e.name, "cancel",    32'(bus.div_cancel_o), 32'(e.cancel));
        if (e.mask[4]) cmpField(e.name, "busy",      32'(bus.div_busy_o),   32'(e.busy));
        if (e.mask[5]) cmpField(e.name, "stall_cnt", 32'(bus.stall_cnt_o),  32'(e.cnt));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s: expectation for cycle %0d missed, now %0d", e.name, e.cyc, cyc);
            end else begin
                checkOutput(e);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        {bus.stallreq_from_if, bus.stallreq_from_id, bus.stallreq_from_ex, bus.stallreq_from_mem,
         bus.div_start_i, bus.div_ready_i, bus.flush_req_i} = R_NONE;
        bus.new_pc_i = '0;

        applyStimulus(R_NONE, 32'h0);
        expectNow("reset", M_ALL, S_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;

        // Stall priority, combinational in the same cycle
        applyStimulus(R_IF | R_ID, 32'h0);
        expectNow("prio_id", M_STALL | M_CNT, S_ID, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        applyStimulus(R_IF | R_ID | R_MEM, 32'h0);
        expectNow("prio_mem", M_STALL | M_CNT, S_MEM, 1'b0, 32'h0, 1'b0, 1'b0, 4'd1);
        applyStimulus(R_NONE, 32'h0);
        expectNow("prio_none", M_STALL | M_CNT, S_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 4'd2);
        applyStimulus(R_EX | R_ID, 32'h0);
        expectNow("prio_ex", M_STALL | M_CNT, S_EX, 1'b0, 32'h0, 1'b0, 1'b0, 4'd2);
        applyStimulus(R_IF, 32'h0);
        expectNow("prio_if", M_STALL | M_CNT, S_IF, 1'b0, 32'h0, 1'b0, 1'b0, 4'd3);
        applyStimulus(R_NONE, 32'h0);
        expectNow("prio_idle", M_STALL | M_CNT, S_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 4'd4);

        // Divide completing on div_ready at cycle 5
        applyStimulus(R_DS, 32'h0);
        expectNow("div_start", M_STALL | M_BUSY, S_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(R_NONE, 32'h0);
            expectNow("div_wait", M_STALL | M_BUSY | M_FLUSH, S_EX, 1'b0, 32'h0, 1'b0, 1'b1, 4'd0);
        end
        applyStimulus(R_DR, 32'h0);
        expectNow("div_ready", M_STALL | M_BUSY | M_CNT, S_NONE, 1'b0, 32'h0, 1'b0, 1'b1, 4'd8);
        applyStimulus(R_NONE, 32'h0);
        expectNow("div_done", M_STALL | M_BUSY | M_CANCEL, S_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);

        // Start and ready together in IDLE: ready is not consumed
        applyStimulus(R_DS | R_DR, 32'h0);
        expectNow("both_idle", M_STALL | M_BUSY, S_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        applyStimulus(R_NONE, 32'h0);
        expectNow("both_wait", M_STALL | M_BUSY, S_EX, 1'b0, 32'h0, 1'b0, 1'b1, 4'd0);
        applyStimulus(R_DR, 32'h0);
        expectNow("both_ready", M_STALL, S_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        applyStimulus(R_NONE, 32'h0);
        expectNow("both_done", M_BUSY | M_CNT, S_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 4'd9);

        // Timeout after 8 DIV_WAIT cycles; counter saturates rather than wrapping
        applyStimulus(R_DS, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(R_NONE, 32'h0);
            expectNow("to_wait", M_STALL | M_BUSY | M_CANCEL, S_EX, 1'b0, 32'h0, 1'b0, 1'b1, 4'd0);
        end
        applyStimulus(R_NONE, 32'h0);
        expectNow("to_cancel", M_STALL | M_BUSY | M_CANCEL | M_CNT, S_NONE, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF);
        applyStimulus(R_DR, 32'h0);
        expectNow("ready_idle", M_STALL | M_BUSY | M_CANCEL, S_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        applyStimulus(R_NONE, 32'h0);
        expectNow("ready_idle2", M_BUSY, S_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);

        // Flush while dividing, with a MEM stall request held high
        applyStimulus(R_DS, 32'h0);
        applyStimulus(R_FL | R_MEM, 32'h0000_0040);
        applyStimulus(R_MEM, 32'h0);
        expectNow("fl_div", M_STALL | M_FLUSH | M_PC | M_CANCEL | M_BUSY, S_NONE, 1'b1, 32'h40, 1'b1, 1'b0, 4'd0);
        applyStimulus(R_MEM, 32'h0);
        expectNow("fl_div2", M_STALL | M_FLUSH | M_CANCEL, S_NONE, 1'b1, 32'h40, 1'b0, 1'b0, 4'd0);
        applyStimulus(R_MEM, 32'h0);
        expectNow("fl_div3", M_STALL | M_FLUSH, S_NONE, 1'b1, 32'h40, 1'b0, 1'b0, 4'd0);
        applyStimulus(R_MEM, 32'h0);
        expectNow("fl_div_end", M_STALL | M_FLUSH | M_PC, S_MEM, 1'b0, 32'h40, 1'b0, 1'b0, 4'd0);

        // Back-to-back flush restarts the count and relatches the target
        applyStimulus(R_FL, 32'h0000_0010);
        applyStimulus(R_NONE, 32'h0);
        expectNow("b2b_1", M_FLUSH | M_PC, S_NONE, 1'b1, 32'h10, 1'b0, 1'b0, 4'd0);
        applyStimulus(R_FL, 32'h0000_0080);
        expectNow("b2b_2", M_FLUSH | M_PC, S_NONE, 1'b1, 32'h10, 1'b0, 1'b0, 4'd0);
        applyStimulus(R_IF, 32'h0);
        expectNow("b2b_3", M_STALL | M_FLUSH | M_PC, S_NONE, 1'b1, 32'h80, 1'b0, 1'b0, 4'd0);
        applyStimulus(R_DS, 32'h0);
        expectNow("b2b_4", M_FLUSH | M_BUSY, S_NONE, 1'b1, 32'h80, 1'b0, 1'b0, 4'd0);
        applyStimulus(R_NONE, 32'h0);
        expectNow("b2b_5", M_FLUSH | M_BUSY, S_NONE, 1'b1, 32'h80, 1'b0, 1'b0, 4'd0);
        applyStimulus(R_NONE, 32'h0);
        expectNow("b2b_end", M_FLUSH | M_PC | M_BUSY, S_NONE, 1'b0, 32'h80, 1'b0, 1'b0, 4'd0);

        // Asynchronous reset in the middle of a divide
        applyStimulus(R_DS, 32'h0);
        applyStimulus(R_NONE, 32'h0);
        expectNow("rst_pre", M_STALL | M_BUSY, S_EX, 1'b0, 32'h0, 1'b0, 1'b1, 4'd0);
        applyStimulus(R_NONE, 32'h0);
        rst = 1'b1;
        expectNow("rst_async", M_ALL, S_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        applyStimulus(R_NONE, 32'h0);
        expectNow("rst_hold", M_ALL, S_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;

        // Hold the IF stall for 20 cycles: counter climbs then saturates at 4'hF
        for (int i = 0; i < 20; i++) begin
            applyStimulus(R_IF, 32'h0);
            expectNow("cnt_run", M_STALL | M_CNT, S_IF, 1'b0, 32'h0, 1'b0, 1'b0,
                      CNT_W'((i > 15) ? 15 : i));
        end
        applyStimulus(R_NONE, 32'h0);
        expectNow("cnt_sat", M_STALL | M_CNT, S_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks += exp_q.size();
            errors += exp_q.size();
            $display("[TB] FAIL scoreboard: %0d expectations never sampled, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
